timer_counter: RTL and testbench

- Memory-mapped programmable down-counter peripheral.
- It is the responder end of the CPU bridge's timer interface; the design instantiates it twice, as TC0 at 0x7F00–0x7F0B and TC1 at 0x7F10–0x7F1B.
- It accepts word writes gated by the bridge's per-timer write strobe and returns register contents on the read path.
- It raises an interrupt request to the CP0 interrupt logic when the count expires.

---
 rtl/timer_counter_pkg.sv | 32 +++
 rtl/timer_counter.sv | 119 +++++++++++
 tb/tb_timer_counter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counter timer: register offsets,
// FSM states, mode encodings and the bus address windows of the two instances.
package timer_counter_pkg;

    localparam logic [1:0] TC_CTRL   = 2'b00;
    localparam logic [1:0] TC_PRESET = 2'b01;
    localparam logic [1:0] TC_COUNT  = 2'b10;
    localparam logic [1:0] TC_RSVD   = 2'b11;

    localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

    localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TC0_LAST = 32'h0000_7F0B;
    localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
    localparam logic [31:0] TC1_LAST = 32'h0000_7F1B;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tc_state_e;

    // Field layout of CTRL[3:0]; bits above 3 are not stored.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } tc_ctrl_t;

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counter with CTRL/PRESET/COUNT registers, one-shot or
// auto-reload operation and a maskable registered interrupt request.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int unsigned RELOAD_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    tc_state_e   state_q, state_d;
    tc_ctrl_t    ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic [1:0]  reg_sel;
    assign reg_sel = Addr[3:2];

    // Address bits outside the decoded field and the documentation-only parameter.
    logic unused_ok;
    assign unused_ok = ^{Addr[31:4], Addr[1:0], 1'(RELOAD_DELAY)};

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the case statements can leave one unassigned and infer a latch.
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        unique case (state_q)
            TC_IDLE: begin
                if (ctrl_q.en) state_d = TC_LOAD;
            end
            TC_LOAD: begin
                count_d = preset_q;
                state_d = TC_CNT;
            end
            TC_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = TC_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = TC_INT;
                end
            end
            TC_INT: begin
                // Modes 10/11 fall into the one-shot branch.
                if (ctrl_q.mode == TC_MODE_RELOAD) begin
                    irq_flag_d = 1'b0;
                    state_d    = TC_LOAD;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = TC_IDLE;
                end
            end
            default: state_d = TC_IDLE;
        endcase

        // A bus write wins over whatever the FSM decided on the same edge.
        if (WE) begin
            case (reg_sel)
                TC_CTRL: begin
                    ctrl_d     = tc_ctrl_t'(Din[3:0]);
                    state_d    = TC_IDLE;
                    irq_flag_d = 1'b0;
                    count_d    = count_q;
                end
                TC_PRESET: begin
                    preset_d   = Din;
                    irq_flag_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= TC_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    assign IRQ = ctrl_q.im & irq_flag_q;

    always_comb begin
        Dout = 32'd0;
        case (reg_sel)
            TC_CTRL:   Dout = {28'd0, ctrl_q};
            TC_PRESET: Dout = preset_q;
            TC_COUNT:  Dout = count_q;
            default:   Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: reset, one-shot, auto-reload,
// masking, stop/restart and bus/FSM collision scenarios with hand-computed values.
module tb_timer_counter;
    import timer_counter_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    timer_counter #(.RELOAD_DELAY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges at 5, 15, ...; stimulus and sampling happen at falling edges.
    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a falling edge; the write lands on the following rising edge.
    task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
        Addr = TC0_BASE | {28'd0, off, 2'b00};
        Din  = data;
        WE   = 1'b1;
        @(negedge clk);
        WE   = 1'b0;
        Din  = 32'd0;
    endtask

    task automatic read_reg(input logic [1:0] off, output logic [31:0] val);
        Addr = TC0_BASE | {28'd0, off, 2'b00};
        #1;
        val = Dout;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0;
        WE    = 1'b0;
        Din   = 32'd0;
        Addr  = TC0_BASE;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            read_reg(2'(i), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_init_off%0d: got %h expected %h", i, v, 32'd0);
            end
        end
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_init_irq: got %b expected 0", IRQ);
        end
        tick();
        reset = 1'b1;
        tick();

        // Mid-run: one-shot with PRESET=1 raises IRQ after edge 3, then reset hits.
        bus_write(TC_PRESET, 32'd1);
        bus_write(TC_CTRL, 32'h9);
        repeat (3) tick();
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_irq: got %b expected 1", IRQ);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_irq: got %b expected 0", IRQ);
        end
        for (int i = 0; i < 3; i++) begin
            read_reg(2'(i), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid_off%0d: got %h expected %h", i, v, 32'd0);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_readback();
        logic [31:0] v;
        bus_write(TC_PRESET, 32'h5);
        bus_write(TC_CTRL, 32'h0);
        read_reg(TC_PRESET, v);
        checks++;
        if (v !== 32'h5) begin
            errors++;
            $display("FAIL readback_preset: got %h expected %h", v, 32'h5);
        end
        read_reg(TC_CTRL, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL readback_ctrl: got %h expected %h", v, 32'h0);
        end
        // Upper CTRL bits are not stored.
        bus_write(TC_CTRL, 32'hFFFF_FFF0);
        read_reg(TC_CTRL, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL readback_ctrl_upper: got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        bus_write(TC_PRESET, 32'd5);
        bus_write(TC_CTRL, 32'h9);      // edge 0
        tick();                         // edge 1 (LOAD)
        for (int e = 2; e <= 6; e++) begin
            tick();
            read_reg(TC_COUNT, v);
            checks++;
            if (v !== 32'(7 - e)) begin
                errors++;
                $display("FAIL oneshot_count_e%0d: got %0d expected %0d", e, v, 7 - e);
            end
            checks++;
            if (IRQ !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_early_irq_e%0d: got %b expected 0", e, IRQ);
            end
        end
        tick();                         // edge 7
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_irq_e7: got %b expected 1", IRQ);
        end
        tick();                         // edge 8
        read_reg(TC_CTRL, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL oneshot_ctrl_after: got %h expected %h", v, 32'h8);
        end
        repeat (2) tick();
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_irq_held: got %b expected 1", IRQ);
        end
        read_reg(TC_COUNT, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL oneshot_count_end: got %0d expected 0", v);
        end
        bus_write(TC_CTRL, 32'h8);
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_clear: got %b expected 0", IRQ);
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        bus_write(TC_PRESET, 32'd3);
        bus_write(TC_CTRL, 32'hB);      // edge 0
        for (int e = 1; e <= 16; e++) begin
            tick();
            checks++;
            if (IRQ !== ((e % 5) == 0)) begin
                errors++;
                $display("FAIL reload_irq_e%0d: got %b expected %b", e, IRQ, (e % 5) == 0);
            end
            if ((e % 5) == 2) begin
                read_reg(TC_COUNT, v);
                checks++;
                if (v !== 32'd3) begin
                    errors++;
                    $display("FAIL reload_count_e%0d: got %0d expected 3", e, v);
                end
            end
        end
        bus_write(TC_CTRL, 32'h0);
    endtask

    task automatic test_mask();
        logic [31:0] v;
        bus_write(TC_PRESET, 32'd2);
        bus_write(TC_CTRL, 32'h1);      // edge 0; INT at edge 4
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (IRQ !== 1'b0) begin
                errors++;
                $display("FAIL mask_irq_e%0d: got %b expected 0", e, IRQ);
            end
        end
        read_reg(TC_COUNT, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL mask_count: got %0d expected 0", v);
        end
        read_reg(TC_CTRL, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL mask_ctrl_en_cleared: got %h expected %h", v, 32'h0);
        end
        bus_write(TC_CTRL, 32'h8);
        tick();
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL mask_unmask_irq: got %b expected 0", IRQ);
        end
    endtask

    task automatic test_stop_restart();
        logic [31:0] v;
        bus_write(TC_PRESET, 32'd100);
        bus_write(TC_CTRL, 32'h1);      // edge 0; COUNT=100 at edge 2
        repeat (12) tick();             // edge 12
        read_reg(TC_COUNT, v);
        checks++;
        if (v !== 32'd90) begin
            errors++;
            $display("FAIL stop_count_e12: got %0d expected 90", v);
        end
        bus_write(TC_CTRL, 32'h0);      // same edge the FSM would decrement
        read_reg(TC_COUNT, v);
        checks++;
        if (v !== 32'd90) begin
            errors++;
            $display("FAIL stop_count_at_write: got %0d expected 90", v);
        end
        repeat (3) tick();
        read_reg(TC_COUNT, v);
        checks++;
        if (v !== 32'd90) begin
            errors++;
            $display("FAIL stop_count_frozen: got %0d expected 90", v);
        end
        bus_write(TC_CTRL, 32'h1);
        tick();
        read_reg(TC_COUNT, v);
        checks++;
        if (v !== 32'd90) begin
            errors++;
            $display("FAIL restart_count_load: got %0d expected 90", v);
        end
        tick();
        read_reg(TC_COUNT, v);
        checks++;
        if (v !== 32'd100) begin
            errors++;
            $display("FAIL restart_count_reload: got %0d expected 100", v);
        end
        tick();
        read_reg(TC_COUNT, v);
        checks++;
        if (v !== 32'd99) begin
            errors++;
            $display("FAIL restart_count_dec: got %0d expected 99", v);
        end
        bus_write(TC_CTRL, 32'h0);
    endtask

    task automatic test_collision();
        logic [31:0] v;
        bus_write(TC_PRESET, 32'd4);
        bus_write(TC_CTRL, 32'h9);      // edge 0; CNT->INT due at edge 6
        repeat (5) tick();              // edge 5
        read_reg(TC_COUNT, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL coll_count_e5: got %0d expected 1", v);
        end
        bus_write(TC_CTRL, 32'h9);      // edge 6
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL coll_irq: got %b expected 0", IRQ);
        end
        read_reg(TC_CTRL, v);
        checks++;
        if (v !== 32'h9) begin
            errors++;
            $display("FAIL coll_ctrl: got %h expected %h", v, 32'h9);
        end
        read_reg(TC_COUNT, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL coll_count_held: got %0d expected 1", v);
        end
        repeat (2) tick();              // LOAD at edge 7, COUNT=4 at edge 8
        read_reg(TC_COUNT, v);
        checks++;
        if (v !== 32'd4) begin
            errors++;
            $display("FAIL coll_count_reload: got %0d expected 4", v);
        end
        bus_write(TC_COUNT, 32'h0000_FFFF);   // edge 9: ignored, FSM decrements
        read_reg(TC_COUNT, v);
        checks++;
        if (v !== 32'd3) begin
            errors++;
            $display("FAIL coll_count_write_ignored: got %0d expected 3", v);
        end
        read_reg(TC_RSVD, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL coll_reserved_read: got %h expected 0", v);
        end
        bus_write(TC_CTRL, 32'h0);
    endtask

    task automatic test_preset_zero();
        logic [31:0] v;
        bus_write(TC_PRESET, 32'd0);
        bus_write(TC_CTRL, 32'h9);      // edge 0
        repeat (2) tick();              // edge 2: CNT entry with COUNT=0
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL pz_irq_e2: got %b expected 0", IRQ);
        end
        tick();                         // edge 3: INT
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("FAIL pz_irq_e3: got %b expected 1", IRQ);
        end
        read_reg(TC_COUNT, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL pz_count: got %0d expected 0", v);
        end
        tick();
        read_reg(TC_CTRL, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL pz_ctrl_after: got %h expected %h", v, 32'h8);
        end
        bus_write(TC_PRESET, 32'd7);    // any PRESET write clears the pending flag
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL pz_preset_clears_irq: got %b expected 0", IRQ);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_readback();
        test_oneshot();
        test_autoreload();
        test_mask();
        test_stop_restart();
        test_collision();
        test_preset_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
